// File: rtl/ahb_lite_pkg.sv
// Shared AHB-lite encodings, subordinate FSM states and the byte-lane strobe helper.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DONE = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sub_state_t;

  // Little-endian lane strobe; only called for already-legal size/alignment.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_lite_sram_bytemem.sv
// Word-organised SRAM with per-byte write strobes and an asynchronous read port.
module ahb_lite_sram_bytemem #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [3:0]                   strb,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_subordinate.sv
// AHB-lite SRAM subordinate: pipelined address/data phase, programmable wait states,
// two-cycle ERROR response for illegal size, alignment or range.
//
// state | meaning
// IDLE  | no data phase in progress, zero-wait OKAY
// WAIT  | legal transfer stalled, down-counter running
// DONE  | legal transfer completes (write commits / read data valid)
// ERR1  | first ERROR cycle, HREADYOUT low
// ERR2  | second ERROR cycle, HREADYOUT high
module ahb_lite_sram_subordinate #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);
  import ahb_lite_pkg::*;

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(MEM_DEPTH * 4);
  localparam logic [1:0] WS_LOAD = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  sub_state_t  state_q, state_d, launch_state;
  logic [1:0]  cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic        accept, legal;
  logic        mem_we;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;

  // Burst type and protection are accepted but have no effect on this memory.
  logic unused_inputs;
  assign unused_inputs = ^{HTRANS[0], HBURST, HPROT};

  assign accept = HSEL & HREADY & HTRANS[1] &
                  ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR2));

  always_comb begin
    legal = 1'b1;
    if (HSIZE > 3'd2) legal = 1'b0;
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) legal = 1'b0;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) legal = 1'b0;
    if (HADDR >= ADDR_LIMIT) legal = 1'b0;
  end

  always_comb begin
    launch_state = ST_DONE;
    if (!legal)                launch_state = ST_ERR1;
    else if (WAIT_STATES > 0)  launch_state = ST_WAIT;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = accept ? launch_state : ST_IDLE;
        if (accept) cnt_d = WS_LOAD;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE;
      end
    end
  end

  // A reset sampled on the completing edge discards the write.
  assign mem_we   = (state_q == ST_DONE) & write_q & ~HRESET;
  assign mem_strb = lane_mask(size_q, addr_q[1:0]);

  ahb_lite_sram_bytemem #(.MEM_DEPTH(MEM_DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .strb  (mem_strb),
    .addr  (addr_q[AW+1:2]),
    .wdata (HWDATA),
    .rdata (mem_rdata)
  );

  assign HREADYOUT = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = ((state_q == ST_DONE) && !write_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_subordinate.sv
// Bench for ahb_lite_sram_subordinate: three instances (0, 2 and 3 wait states)
// driven by a pipelined manager, checked per cycle against a transfer-level model.
module tb_ahb_lite_sram_subordinate;
  import ahb_lite_pkg::*;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_mask;
  } op_t;

  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite, hready;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [2:0]  sel_v, ho_v, hr_v;
  logic [31:0] hd0, hd1, hd2;
  logic        ho, hr;
  logic [31:0] hd;
  int          cur = 0;

  int n_checks = 0, n_pass = 0;
  int ctx_op = 0, ctx_cyc = 0;

  logic [31:0] mmem   [3][256];
  logic [3:0]  mknown [3][256];

  assign sel_v = {hsel && (cur == 2), hsel && (cur == 1), hsel && (cur == 0)};

  always_comb begin
    ho = ho_v[0]; hr = hr_v[0]; hd = hd0;
    if (cur == 1) begin ho = ho_v[1]; hr = hr_v[1]; hd = hd1; end
    if (cur == 2) begin ho = ho_v[2]; hr = hr_v[2]; hd = hd2; end
  end
  assign hready = ho;

  ahb_lite_sram_subordinate #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .HRESET(hreset), .HSEL(sel_v[0]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ho_v[0]), .HRESP(hr_v[0]), .HRDATA(hd0));
  ahb_lite_sram_subordinate #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .HRESET(hreset), .HSEL(sel_v[1]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ho_v[1]), .HRESP(hr_v[1]), .HRDATA(hd1));
  ahb_lite_sram_subordinate #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .HRESET(hreset), .HSEL(sel_v[2]), .HADDR(haddr), .HWRITE(hwrite),
    .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready), .HREADYOUT(ho_v[2]), .HRESP(hr_v[2]), .HRDATA(hd2));

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d op%0d cyc%0d: got %b want %b", name, cur, ctx_op, ctx_cyc, act, exp);
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d op%0d cyc%0d: got %h want %h", name, cur, ctx_op, ctx_cyc, act, exp);
  endtask

  function automatic op_t idle_op();
    op_t o;
    o.sel = 1'b0; o.trans = ID; o.write = 1'b0; o.addr = '0; o.size = 3'd0;
    o.burst = HBURST_SINGLE; o.wdata = '0; o.exp_err = 1'b0; o.exp_rdata = '0; o.exp_mask = '0;
    return o;
  endfunction

  function automatic op_t mk(input logic [1:0] t, input logic w, input logic [31:0] a,
                             input logic [2:0] s, input logic [31:0] wd,
                             input logic e, input logic [31:0] rd);
    op_t o;
    o = idle_op();
    o.sel = 1'b1; o.trans = t; o.write = w; o.addr = a; o.size = s; o.wdata = wd;
    o.exp_err = e; o.exp_rdata = rd; o.exp_mask = '1;
    return o;
  endfunction

  function automatic op_t mkb(input logic [1:0] t, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd);
    op_t o;
    o = mk(t, w, a, 3'd2, wd, 1'b0, rd);
    o.burst = HBURST_INCR4;
    return o;
  endfunction

  // Transfer-level reference: legality from plain arithmetic, memory as a byte-tracked array.
  function automatic op_t model_xfer(input int d, input op_t o);
    int nbytes, w, lane;
    o.exp_err = 1'b0; o.exp_rdata = '0; o.exp_mask = '0;
    if (!(o.sel && o.trans[1])) return o;
    nbytes = 1 << o.size;
    if (o.size > 3'd2 || (o.addr % nbytes) != 0 || o.addr >= 32'd1024) begin
      o.exp_err = 1'b1;
      return o;
    end
    w = int'(o.addr / 4);
    if (o.write) begin
      for (int b = 0; b < nbytes; b++) begin
        lane = int'(o.addr % 4) + b;
        mmem[d][w][8*lane +: 8] = o.wdata[8*lane +: 8];
        mknown[d][w][lane] = 1'b1;
      end
    end else begin
      o.exp_rdata = mmem[d][w];
      for (int b = 0; b < 4; b++) o.exp_mask[8*b +: 8] = {8{mknown[d][w][b]}};
    end
    return o;
  endfunction

  task automatic drive(input op_t a, input logic [31:0] wd);
    hsel = a.sel; htrans = a.trans; haddr = a.addr; hwrite = a.write;
    hsize = a.size; hburst = a.burst; hprot = 4'b0011; hwdata = wd;
  endtask

  // Pipelined manager: holds the address phase while the current data phase stalls.
  task automatic run_ops(input op_t list[$]);
    op_t dp, ap;
    int  nc, ws;
    logic act;
    ws = (cur == 0) ? 0 : (cur == 1) ? 2 : 3;
    dp = idle_op();
    for (int i = 0; i <= list.size(); i++) begin
      ap  = (i < list.size()) ? list[i] : idle_op();
      act = dp.sel && dp.trans[1];
      nc  = !act ? 1 : dp.exp_err ? 2 : ws + 1;
      for (int k = 0; k < nc; k++) begin
        @(negedge clk);
        ctx_op = i - 1; ctx_cyc = k;
        if (!act) begin
          chk_bit("ready_idle", ho, 1'b1);
          chk_bit("resp_idle", hr, 1'b0);
          chk_word("rdata_idle", hd, 32'h0);
        end else if (dp.exp_err) begin
          chk_bit("ready_err", ho, k == 1);
          chk_bit("resp_err", hr, 1'b1);
          chk_word("rdata_err", hd, 32'h0);
        end else begin
          chk_bit("ready_ok", ho, k == ws);
          chk_bit("resp_ok", hr, 1'b0);
          if (k < ws) chk_word("rdata_wait", hd, 32'h0);
          else if (!dp.write) chk_word("rdata", hd & dp.exp_mask, dp.exp_rdata & dp.exp_mask);
        end
        drive(ap, dp.write ? dp.wdata : 32'h0);
      end
      dp = ap;
    end
  endtask

  op_t dir_tab[$];
  op_t q[$];
  op_t tmp;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dir_tab = '{
      mk(NS, 1, 32'h010, 3'd2, 32'hDEADBEEF, 0, 32'h0),
      mk(NS, 0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF),
      mk(NS, 1, 32'h020, 3'd2, 32'h00000000, 0, 32'h0),
      mk(NS, 1, 32'h022, 3'd0, 32'hABABABAB, 0, 32'h0),
      mk(NS, 1, 32'h020, 3'd1, 32'h12341234, 0, 32'h0),
      mk(NS, 0, 32'h020, 3'd2, 32'h0,        0, 32'h00AB1234),
      mk(NS, 1, 32'h402, 3'd2, 32'hFFFFFFFF, 1, 32'h0),
      mk(NS, 1, 32'h400, 3'd2, 32'hFFFFFFFF, 1, 32'h0),
      mk(NS, 1, 32'h011, 3'd1, 32'hFFFFFFFF, 1, 32'h0),
      mk(NS, 1, 32'h010, 3'd3, 32'hFFFFFFFF, 1, 32'h0),
      mk(NS, 0, 32'h010, 3'd2, 32'h0,        0, 32'hDEADBEEF),
      mk(ID, 0, 32'h000, 3'd0, 32'h0,        0, 32'h0),
      mkb(NS, 1, 32'h030, 32'hA0000000, 32'h0),
      mkb(BZ, 1, 32'h034, 32'h0,        32'h0),
      mkb(SQ, 1, 32'h034, 32'hA0000001, 32'h0),
      mkb(SQ, 1, 32'h038, 32'hA0000002, 32'h0),
      mkb(ID, 0, 32'h03C, 32'h0,        32'h0),
      mkb(SQ, 1, 32'h03C, 32'hA0000003, 32'h0),
      mkb(NS, 0, 32'h030, 32'h0,        32'hA0000000),
      mkb(SQ, 0, 32'h034, 32'h0,        32'hA0000001),
      mkb(BZ, 0, 32'h038, 32'h0,        32'h0),
      mkb(SQ, 0, 32'h038, 32'h0,        32'hA0000002),
      mkb(SQ, 0, 32'h03C, 32'h0,        32'hA0000003),
      mk(NS, 1, 32'h3FC, 3'd2, 32'h5A5A5A5A, 0, 32'h0),
      mk(NS, 0, 32'h3FC, 3'd2, 32'h0,        0, 32'h5A5A5A5A),
      mk(NS, 0, 32'h3FE, 3'd1, 32'h0,        0, 32'h5A5A5A5A),
      mk(NS, 0, 32'h400, 3'd0, 32'h0,        1, 32'h0)
    };

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 256; w++) begin mmem[d][w] = '0; mknown[d][w] = 4'h0; end

    hreset = 1'b1;
    drive(idle_op(), 32'h0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      cur = d;
      #0;
      ctx_op = -1; ctx_cyc = 0;
      chk_bit("reset_ready", ho, 1'b1);
      chk_bit("reset_resp", hr, 1'b0);
      chk_word("reset_rdata", hd, 32'h0);
    end
    hreset = 1'b0;

    // Directed table on every wait-state variant.
    for (int d = 0; d < 3; d++) begin
      cur = d;
      foreach (dir_tab[i]) tmp = model_xfer(d, dir_tab[i]);
      run_ops(dir_tab);
    end

    // Reset in the middle of a stalled write.
    cur = 1;
    q.delete();
    q.push_back(model_xfer(1, mk(NS, 1, 32'h050, 3'd2, 32'h11111111, 0, 32'h0)));
    run_ops(q);
    ctx_op = -2;
    @(negedge clk); drive(mk(NS, 1, 32'h050, 3'd2, 32'h0, 0, 32'h0), 32'h0);
    @(negedge clk); ctx_cyc = 0;
    chk_bit("midwr_ready", ho, 1'b0);
    drive(idle_op(), 32'h22222222);
    hreset = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); ctx_cyc = c;
      chk_bit("rst_ready", ho, 1'b1);
      chk_bit("rst_resp", hr, 1'b0);
      chk_word("rst_rdata", hd, 32'h0);
    end
    hreset = 1'b0;
    q.delete();
    q.push_back(model_xfer(1, mk(NS, 0, 32'h050, 3'd2, 32'h0, 0, 32'h0)));
    run_ops(q);

    // Randomized traffic around a small window and the top-of-memory boundary.
    for (int d = 0; d < 3; d++) begin
      cur = d;
      q.delete();
      for (int n = 0; n < 60; n++) begin
        int r;
        op_t o;
        o = idle_op();
        r = int'($urandom_range(0, 9));
        o.trans = (r < 2) ? ID : (r < 3) ? BZ : (r < 7) ? NS : SQ;
        o.sel   = ($urandom_range(0, 9) != 0);
        o.write = 1'($urandom_range(0, 1));
        o.size  = ($urandom_range(0, 11) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        o.addr  = ($urandom_range(0, 7) == 0) ? 32'h3F8 + $urandom_range(0, 15)
                                              : 32'h080 + $urandom_range(0, 31);
        o.burst = 3'($urandom_range(0, 7));
        o.wdata = $urandom;
        q.push_back(model_xfer(d, o));
      end
      run_ops(q);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
